// File: rtl/rf_pkg.sv
// Shared defaults and address-width derivation for the scoreboarded register file.
package rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRP_DEF  = 2;

    // Smallest w with 2**w >= nreg.
    function automatic int addr_width(input int nreg);
        int w;
        w = 0;
        while ((32'sd1 <<< w) < nreg) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks outstanding writes, generates the WAW issue stall
// and keeps a registered count of busy registers.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = addr_width(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    output logic [NREG-1:0] busy,
    output logic            iss_ready,
    output logic [AW:0]     busy_cnt
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_next_s;
    logic [AW:0]     cnt_r;
    logic            wb_hit_iss_s;
    logic            iss_ready_s;
    logic            fire_s;
    logic            clr_s;
    logic            inc_s;
    logic            dec_s;

    // Ready, fire and next busy vector; a same-cycle reservation overrides the clear.
    always_comb begin
        wb_hit_iss_s = wb_valid && (wb_rd == iss_rd);
        iss_ready_s  = !((iss_rd != {AW{1'b0}}) && busy_r[iss_rd] && !wb_hit_iss_s);
        fire_s       = iss_valid && iss_ready_s && (iss_rd != {AW{1'b0}});
        clr_s        = wb_valid && (wb_rd != {AW{1'b0}});
        inc_s        = fire_s && !busy_r[iss_rd];
        dec_s        = clr_s && busy_r[wb_rd] && !(fire_s && wb_hit_iss_s);
        busy_next_s  = busy_r;
        if (clr_s) begin
            busy_next_s[wb_rd] = 1'b0;
        end else begin
            busy_next_s = busy_r;
        end
        if (fire_s) begin
            busy_next_s[iss_rd] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
    end

    // Busy vector and counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= {NREG{1'b0}};
            cnt_r  <= {(AW+1){1'b0}};
        end else begin
            busy_r <= busy_next_s;
            cnt_r  <= cnt_r + {{AW{1'b0}}, inc_s} - {{AW{1'b0}}, dec_s};
        end
    end

    assign busy      = busy_r;
    assign iss_ready = iss_ready_s;
    assign busy_cnt  = cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with asynchronous reads, optional writeback
// forwarding and a busy-bit scoreboard for in-flight destinations.
module regfile_sb
    import rf_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREG   = NREG_DEF,
    parameter  int NRP    = NRP_DEF,
    parameter  int BYPASS = 1,
    localparam int AW     = addr_width(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRP*AW-1:0] rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]    rd_busy,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_ready,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [AW:0]       busy_cnt
);

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] busy_s;
    logic            wr_en_s;

    assign wr_en_s = wb_valid && (wb_rd != {AW{1'b0}});

    rf_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .busy      (busy_s),
        .iss_ready (iss_ready),
        .busy_cnt  (busy_cnt)
    );

    // Register storage; entry 0 is never written and stays at its reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[wb_rd] <= wb_data;
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_port
        logic [AW-1:0]   addr_s;
        logic            hit_s;
        logic [XLEN-1:0] data_s;
        logic            bsy_s;

        assign addr_s = rd_addr[p*AW +: AW];
        assign hit_s  = (BYPASS != 32'sd0) && wb_valid && (wb_rd == addr_s);

        // Per-port read mux: r0 is hardwired, forwarding beats stored state.
        always_comb begin
            if (addr_s == {AW{1'b0}}) begin
                data_s = {XLEN{1'b0}};
                bsy_s  = 1'b0;
            end else if (hit_s) begin
                data_s = wb_data;
                bsy_s  = 1'b0;
            end else begin
                data_s = regs_r[addr_s];
                bsy_s  = busy_s[addr_s];
            end
        end

        assign rd_data[p*XLEN +: XLEN] = data_s;
        assign rd_busy[p]              = bsy_s;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=2); AW = log2(NREG).
REQ-003 SHALL have parameter NRP, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, 1 = write-to-read forwarding enabled.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 rd_addr  input  NRP*AW  read addresses, port p at bits [p*AW +: AW].
REQ-008 rd_data  output  NRP*XLEN  read data per port, combinational.
REQ-009 rd_busy  output  NRP  per-port busy flag: register has an outstanding write.
REQ-010 iss_valid  input  1  issue request: reserve destination register.
REQ-011 iss_rd  input  AW  destination register of the issue.
REQ-012 iss_ready  output  1  issue can be accepted this cycle.
REQ-013 wb_valid  input  1  writeback strobe.
REQ-014 wb_rd  input  AW  writeback register.
REQ-015 wb_data  input  XLEN  writeback data.
REQ-016 busy_cnt  output  AW+1  number of registers currently busy.

Function
REQ-017 Register 0 SHALL read as 0, never be written, never be busy.
REQ-018 Reads SHALL be asynchronous: rd_data[p] = regs[rd_addr[p]], rd_busy[p] = busy[rd_addr[p]].
REQ-019 With BYPASS=1, when wb_valid and wb_rd == rd_addr[p] != 0, rd_data[p] SHALL equal wb_data and rd_busy[p] SHALL be 0 in the same cycle; BYPASS=0 returns old value and current busy.
REQ-020 wb_valid with wb_rd != 0 SHALL write wb_data and clear busy[wb_rd] at the next edge, regardless of prior busy state.
REQ-021 iss_ready SHALL be 0 iff iss_rd != 0 and busy[iss_rd] = 1 and not (wb_valid and wb_rd == iss_rd) (WAW stall, writeback-same-cycle releases it).
REQ-022 Issue fires when iss_valid and iss_ready; fire with iss_rd != 0 SHALL set busy[iss_rd] at next edge; fire to register 0 SHALL be accepted with no state change.
REQ-023 Simultaneous fire and writeback to same register SHALL write data and leave busy set (new reservation wins).
REQ-024 busy_cnt SHALL be registered, updated each edge: +1 on busy set, -1 on busy clear, net 0 when both hit different registers or the same register per REQ-023; never exceeds NREG-1.
REQ-025 iss_ready SHALL not depend on iss_valid (no combinational loop for requesters).
REQ-026 Write and read of the same register in one cycle with BYPASS=0 SHALL return the pre-write value.

Reset
REQ-027 reset SHALL clear all registers to 0, all busy bits to 0, busy_cnt to 0 at the next edge, overriding concurrent writeback or issue.
REQ-028 Reset asserted mid-operation SHALL discard all outstanding reservations; after release, iss_ready = 1 for every register.
REQ-029 No output SHALL depend on state not covered by reset.

Structure
REQ-030 A shared package rf_pkg SHALL hold default XLEN, NREG, NRP and the AW derivation function.
REQ-031 Busy-bit vector, ready logic and busy_cnt SHALL live in sub-module rf_scoreboard; storage and read muxing stay in regfile_sb.

Verification
REQ-032 Reset then read all ports at addresses 0..NREG-1 -> rd_data = 0, rd_busy = 0, busy_cnt = 0, iss_ready = 1.
REQ-033 Issue r5; next cycle issue r5 again -> iss_ready = 0, busy_cnt = 1; wb r5 = 0xDEADBEEF same cycle -> iss_ready = 1, after edge busy[5] = 1, regs[5] = 0xDEADBEEF, busy_cnt = 1.
REQ-034 BYPASS=1: wb r7 = 0x12345678 with rd_addr[0] = 7, rd_addr[1] = 0 -> port0 = 0x12345678 busy 0, port1 = 0 same cycle.
REQ-035 wb r0 = 0xFFFFFFFF and issue r0 -> iss_ready = 1, read r0 = 0, busy_cnt unchanged.
REQ-036 Issue r1, r2, r3 on successive cycles, then reset with wb r2 = 0xAA -> busy_cnt = 0, regs[2] = 0 after edge.
REQ-037 Issue r4 and wb r9 = 0x55 same cycle with r9 busy -> busy_cnt unchanged, busy[4] = 1, busy[9] = 0.
